// File: rtl/wave_sched_gen.sv
// wave_sched_gen: scheduled-waveform source driving wave_out through (duration, level) segments.
// Ports: clk/rst (sync, active-high); cfg_we/cfg_addr/cfg_dur/cfg_lvl write the segment table in IDLE;
// cfg_last/cfg_loop/init_lvl are sampled on an accepted start; start/stop control the run;
// wave_out (registered), busy (RUN), seg_idx (segment counting), done (final-segment pulse).
// Define WAVE_SCHED_GEN_ABS_TIME_EN to treat durations as absolute offsets from the start edge.
module wave_sched_gen #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic             cfg_lvl,
  input  logic [IDX_W-1:0] cfg_last,
  input  logic             cfg_loop,
  input  logic             init_lvl,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             busy,
  output logic [IDX_W-1:0] seg_idx,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, nidx;
  logic loop_q, loop_d, wave_q, wave_d, done_q, done_d;
  logic hit, fin, go, tick, we;
  logic [CNT_W-1:0] dur_q [DEPTH];
  logic [CNT_W-1:0] dur_d [DEPTH];
  logic [DEPTH-1:0] lvl_q, lvl_d;
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
  logic [CNT_W-1:0] elap;
`endif

  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] d);
    return d == '0 ? CNT_W'(1) : d;
  endfunction

  assign go   = state_q == IDLE && start && !stop;
  // done_q marks the extra RUN cycle after the final apply; the state leaves RUN on the next edge
  assign tick = state_q == RUN && !stop && !done_q;
  assign we   = state_q == IDLE && cfg_we;
  assign fin  = idx_q == last_q;
  assign nidx = fin ? '0 : idx_q + IDX_W'(1);
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
  // cnt holds elapsed cycles since the start edge, saturating so late entries still apply
  assign elap = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign hit  = elap >= eff(dur_q[idx_q]);
`else
  // cnt counts down from eff(k); reaching 1 means this edge applies the level
  assign hit  = cnt_q == CNT_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      wave_q  <= 1'b0;
      done_q  <= 1'b0;
      dur_q   <= '{default: '0};
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb state_d = state_q == IDLE ? (go ? RUN : IDLE) : (stop || done_q ? IDLE : RUN);

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    last_d = last_q;
    loop_d = loop_q;
    wave_d = wave_q;
    done_d = 1'b0;
    dur_d  = dur_q;
    lvl_d  = lvl_q;
    if (we) begin
      dur_d[cfg_addr] = cfg_dur;
      lvl_d[cfg_addr] = cfg_lvl;
    end
    if (go) begin
      wave_d = init_lvl;
      idx_d  = '0;
      last_d = cfg_last;
      loop_d = cfg_loop;
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
      cnt_d  = '0;
`else
      cnt_d  = eff(dur_q[0]);
`endif
    end
    if (tick) begin
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
      cnt_d = hit && fin ? '0 : elap;
`else
      cnt_d = hit ? eff(dur_q[nidx]) : cnt_q - CNT_W'(1);
`endif
      if (hit) begin
        wave_d = lvl_q[idx_q];
        done_d = fin && !loop_q;
        idx_d  = fin && !loop_q ? idx_q : nidx;
      end
    end
  end

  assign wave_out = wave_q;
  assign busy     = state_q == RUN;
  assign seg_idx  = idx_q;
  assign done     = done_q;
endmodule

// File: tb/tb_wave_sched_gen.sv
// tb_wave_sched_gen: directed checks of wave_sched_gen; "t" counts rising edges after the start edge (t=0).
module tb_wave_sched_gen;
  localparam int DEPTH = 8, CNT_W = 16, IDX_W = 3;
  logic clk = 0, rst = 1, cfg_we = 0, cfg_lvl = 0, cfg_loop = 0, init_lvl = 0, start = 0, stop = 0;
  logic [IDX_W-1:0] cfg_addr = '0, cfg_last = '0;
  logic [CNT_W-1:0] cfg_dur = '0;
  logic wave_out, busy, done;
  logic [IDX_W-1:0] seg_idx;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  wave_sched_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dur(cfg_dur), .cfg_lvl(cfg_lvl),
    .cfg_last(cfg_last), .cfg_loop(cfg_loop), .init_lvl(init_lvl), .start(start), .stop(stop),
    .wave_out(wave_out), .busy(busy), .seg_idx(seg_idx), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d, input int l);
    cfg_addr = IDX_W'(a);
    cfg_dur  = CNT_W'(d);
    cfg_lvl  = l[0];
    cfg_we   = 1;
    tick();
    cfg_we   = 0;
  endtask

  task automatic go(input int last, input int lp, input int il);
    cfg_last = IDX_W'(last);
    cfg_loop = lp[0];
    init_lvl = il[0];
    start    = 1;
    tick();
    start    = 0;
  endtask

  task automatic load_s1();
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
    wr(0, 25, 1); wr(1, 60, 0); wr(2, 100, 1); wr(3, 110, 0);
`else
    wr(0, 25, 1); wr(1, 35, 0); wr(2, 40, 1); wr(3, 10, 0);
`endif
  endtask

  // level transitions at 25/60/100/110 in both duration modes
  function automatic logic s1_wave(input int t);
    return t >= 110 ? 1'b0 : t >= 100 ? 1'b1 : t >= 60 ? 1'b0 : t >= 25 ? 1'b1 : 1'b0;
  endfunction

  function automatic int s1_idx(input int t);
    return t >= 100 ? 3 : t >= 60 ? 2 : t >= 25 ? 1 : 0;
  endfunction

  // dur={0,3} looping: relative repeats every 4 edges, absolute every 3
  function automatic logic s3_wave(input int t);
`ifdef WAVE_SCHED_GEN_ABS_TIME_EN
    return t == 0 ? 1'b0 : (t % 3 != 0);
`else
    return t == 0 ? 1'b0 : (t % 4 != 0);
`endif
  endfunction

  initial begin
    tick(); tick();
    rst = 0;
    check("rst wave", wave_out, 0);
    check("rst busy", busy, 0);
    check("rst idx", seg_idx, 0);
    check("rst done", done, 0);

    // scenario 1, with a write and a start attempted at edge 20 and a start on the done cycle
    load_s1();
    go(3, 0, 0);
    check("s1 busy t0", busy, 1);
    check("s1 wave t0", wave_out, 0);
    for (int t = 1; t <= 115; t++) begin
      if (t == 20) begin
        cfg_addr = 0; cfg_dur = 5; cfg_lvl = 0; cfg_we = 1; start = 1;
      end
      if (t == 111) start = 1;
      tick();
      cfg_we = 0; start = 0;
      check($sformatf("s1 wave t=%0d", t), wave_out, s1_wave(t));
      check($sformatf("s1 done t=%0d", t), done, t == 110);
      check($sformatf("s1 busy t=%0d", t), busy, t <= 110);
      check($sformatf("s1 idx t=%0d", t), seg_idx, s1_idx(t));
    end

    // stop sampled at edge 31; table still holds scenario 1 values
    go(3, 0, 0);
    for (int t = 1; t <= 40; t++) begin
      stop = t == 31;
      tick();
      stop = 0;
      check($sformatf("s4 busy t=%0d", t), busy, t < 31);
      check($sformatf("s4 wave t=%0d", t), wave_out, s1_wave(t));
      check($sformatf("s4 idx t=%0d", t), seg_idx, s1_idx(t));
      check($sformatf("s4 done t=%0d", t), done, 0);
    end

    // stop on the final-apply edge wins over the level and done
    go(3, 0, 0);
    for (int t = 1; t <= 115; t++) begin
      stop = t == 110;
      tick();
      stop = 0;
      check($sformatf("s5 wave t=%0d", t), wave_out, t >= 110 ? 1'b1 : s1_wave(t));
      check($sformatf("s5 done t=%0d", t), done, 0);
      check($sformatf("s5 busy t=%0d", t), busy, t < 110);
    end
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    check("s5 start+stop busy", busy, 0);
    tick();
    check("s5 start+stop busy2", busy, 0);
    check("s5 start+stop wave", wave_out, 1);

    // zero duration with loop
    wr(0, 0, 1); wr(1, 3, 0);
    go(1, 1, 0);
    check("s3 wave t0", wave_out, 0);
    for (int t = 1; t <= 24; t++) begin
      tick();
      check($sformatf("s3 wave t=%0d", t), wave_out, s3_wave(t));
      check($sformatf("s3 done t=%0d", t), done, 0);
      check($sformatf("s3 busy t=%0d", t), busy, 1);
    end
    stop = 1;
    tick();
    stop = 0;
    check("s3 stop busy", busy, 0);

    // reset sampled at edge 50, then a run over the cleared table
    load_s1();
    go(3, 0, 0);
    for (int t = 1; t <= 50; t++) begin
      rst = t == 50;
      tick();
      rst = 0;
      if (t < 50) check($sformatf("s6 wave t=%0d", t), wave_out, s1_wave(t));
    end
    check("s6 rst wave", wave_out, 0);
    check("s6 rst busy", busy, 0);
    check("s6 rst idx", seg_idx, 0);
    check("s6 rst done", done, 0);
    go(3, 0, 1);
    check("s6 wave t0", wave_out, 1);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check($sformatf("s6 wave t=%0d", t), wave_out, 0);
      check($sformatf("s6 idx t=%0d", t), seg_idx, t > 3 ? 3 : t);
      check($sformatf("s6 done t=%0d", t), done, t == 4);
      check($sformatf("s6 busy t=%0d", t), busy, t <= 4);
    end

    // full-scale duration must not wrap
    wr(0, 65535, 1);
    go(0, 0, 0);
    for (int t = 1; t <= 65536; t++) begin
      tick();
      if (t == 65534) begin
        check("max wave 65534", wave_out, 0);
        check("max busy 65534", busy, 1);
      end
      if (t == 65535) begin
        check("max wave 65535", wave_out, 1);
        check("max done 65535", done, 1);
      end
      if (t == 65536) begin
        check("max busy 65536", busy, 0);
        check("max done 65536", done, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wave_sched_gen.md
Name: wave_sched_gen

Overview:
- Synthesizable scheduled-waveform source. It drives a single-bit output through a programmed sequence of (duration, level) segments, cycle-accurate to clk.
- It is the generator counterpart of the team's delay-sampling stimulus blocks. It produces timed level changes that downstream samplers and checkers capture.
- It sits between a config/control master (a register block or a bench driver) and the signal under test.

Parameters:
- DEPTH, 8, number of segment table entries (power of 2, ≥2).
- CNT_W, 16, width of segment durations and of the cycle counter.
- IDX_W, $clog2(DEPTH), table index width (derived, not overridden).

Ports:
- clk  input  1  single clock, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  table write strobe.
- cfg_addr  input  IDX_W  table entry to write.
- cfg_dur  input  CNT_W  segment duration written to the entry.
- cfg_lvl  input  1  segment level written to the entry.
- cfg_last  input  IDX_W  index of the final segment; sampled when start is accepted.
- cfg_loop  input  1  restart at segment 0 after the final segment; sampled when start is accepted.
- init_lvl  input  1  level driven from start until segment 0 applies.
- start  input  1  begin a sequence (honoured only in IDLE).
- stop  input  1  abort a sequence.
- wave_out  output  1  generated waveform, registered.
- busy  output  1  high in RUN.
- seg_idx  output  IDX_W  index of the segment currently counting.
- done  output  1  one-cycle pulse when the final segment is applied (non-loop mode only).

Behaviour:
- Reset (rst=1 at an edge), from any state, including mid-sequence:
  - State goes to IDLE.
  - wave_out=0, busy=0, seg_idx=0, done=0.
  - All table entries cleared to dur=0, lvl=0.
- Table writes:
  - cfg_we=1 in IDLE writes {cfg_dur, cfg_lvl} to cfg_addr at that edge.
  - cfg_we while busy=1 is ignored; the table is unchanged.
- Effective duration: eff(k) = max(dur[k], 1). A zero duration is treated as 1 cycle.
- States are IDLE, RUN.
- IDLE -> RUN: start=1 and stop=0 at edge T.
  - At T: wave_out<=init_lvl, busy<=1, seg_idx<=0, counter<=eff(0).
  - cfg_last and cfg_loop are latched at T.
- RUN:
  - The counter decrements each cycle.
  - When it reaches its terminal value, wave_out<=lvl[seg_idx].
  - Timing rule: wave_out equals lvl[i] starting at cycle T + sum over k=0..i of eff(k). Cycle T is the start edge.
  - Non-final segment (seg_idx≠latched last): seg_idx increments and the counter reloads eff(next).
  - Final segment with loop=0: done=1 for exactly that cycle, busy<=0, state to IDLE, wave_out holds its last level.
  - Final segment with loop=1: no done, seg_idx<=0, counter reloads eff(0), state stays in RUN. There is no gap cycle between iterations.
- stop=1 in RUN:
  - Next cycle: state to IDLE, busy=0, done=0.
  - wave_out holds its current value and seg_idx holds.
  - If stop coincides with the final-segment apply, stop wins: the level is not applied and done is not pulsed.
- start in RUN is ignored.
- start and stop together in IDLE: stop wins and the block stays in IDLE.
- start on the same edge done pulses: ignored, because the state is still RUN at that edge.
- cfg_last=0: single-segment sequence.
- Counter arithmetic is unsigned CNT_W. A duration of 2^CNT_W-1 must be honoured exactly, with no wrap.

Optional Feature:
- Macro: WAVE_SCHED_GEN_ABS_TIME_EN.
- Defined (absolute mode):
  - dur[k] is an absolute cycle offset from the start edge T.
  - A CNT_W elapsed counter clears at T and increments each RUN cycle, saturating at all-ones.
  - Segment i applies at the first cycle where elapsed ≥ max(dur[i], 1).
  - A late or non-increasing entry therefore applies one cycle after the previous segment.
  - On loop, elapsed clears together with the reload of segment 0.
- Undefined: relative durations exactly as in Behaviour; the elapsed counter is not present.

Test Plan:
1. Relative run.
   - Stimulus: dur={25,35,40,10}, lvl={1,0,1,0}, cfg_last=3, loop=0, init_lvl=0, start at T=0.
   - Response: wave_out=0 until 24, 1 at 25, 0 at 60, 1 at 100, 0 at 110; done pulses at 110 only; busy=0 from 111.
2. Absolute mode (WAVE_SCHED_GEN_ABS_TIME_EN defined).
   - Stimulus: dur={25,60,100,110}, lvl={1,0,1,0}; same start.
   - Response: identical transitions at 25/60/100/110.
3. Zero duration and loop.
   - Stimulus: dur={0,3}, lvl={1,0}, cfg_last=1, loop=1, init_lvl=0, start at 0.
   - Response: wave_out 1 at 1, 0 at 4, 1 at 5, 0 at 8, repeating; done never asserts.
4. Stop, writes and start while busy.
   - Stimulus: stop at cycle 30 of scenario 1.
   - Response: busy=0 at 31, wave_out stays 1, seg_idx stays 1, no done.
   - Stimulus: cfg_we and start issued at cycle 20.
   - Response: table unchanged, sequence unaffected.
5. Coincident events.
   - Stimulus: stop asserted at cycle 110 of scenario 1.
   - Response: wave_out stays 1, done=0.
   - Stimulus: start and stop together in IDLE.
   - Response: no start, busy stays 0.
6. Reset mid-run.
   - Stimulus: rst=1 at cycle 50.
   - Response: next cycle wave_out=0, busy=0, seg_idx=0; table reads back all zero; a new start with the table unwritten gives 1-cycle segments of level 0.
